// File: rtl/cnn_accel_pkg.sv
// Shared widths, FSM state encoding and helpers for the CNN accelerator MAC path.
package cnn_accel_pkg;

  localparam int INPUT_BIT_WIDTH   = 8;
  localparam int PRODUCT_BIT_WIDTH = 20;
  localparam int ACC_BIT_WIDTH     = 24;
  localparam int ADDR_WIDTH        = 4;
  localparam int DRAIN_CYCLES      = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  function automatic logic [ACC_BIT_WIDTH-1:0] zext_product(
    input logic [PRODUCT_BIT_WIDTH-1:0] p
  );
    return {{(ACC_BIT_WIDTH-PRODUCT_BIT_WIDTH){1'b0}}, p};
  endfunction

endpackage

// File: rtl/mac_window_sequencer_if.sv
// Signal bundle between the window sequencer, layer controller, operand buffer and multiplier.
interface mac_window_sequencer_if;
  import cnn_accel_pkg::*;

  logic                         start;
  logic [ADDR_WIDTH-1:0]        tap_count;
  logic                         busy;
  logic                         rd_en;
  logic [ADDR_WIDTH-1:0]        rd_addr;
  logic [INPUT_BIT_WIDTH-1:0]   rd_neuron;
  logic [INPUT_BIT_WIDTH-1:0]   rd_weight;
  logic                         multi_en;
  logic [INPUT_BIT_WIDTH-1:0]   multiplicator;
  logic [INPUT_BIT_WIDTH-1:0]   multiplicand;
  logic [PRODUCT_BIT_WIDTH-1:0] product;
  logic                         acc_valid;
  logic [ACC_BIT_WIDTH-1:0]     acc_data;
  logic                         acc_ready;

  // Environment side: controller, operand buffer and multiplier.
  modport master (
    output start, tap_count, rd_neuron, rd_weight, product, acc_ready,
    input  busy, rd_en, rd_addr, multi_en, multiplicator, multiplicand,
           acc_valid, acc_data
  );

  // Sequencer side.
  modport slave (
    input  start, tap_count, rd_neuron, rd_weight, product, acc_ready,
    output busy, rd_en, rd_addr, multi_en, multiplicator, multiplicand,
           acc_valid, acc_data
  );

endinterface

// File: rtl/mac_accumulator.sv
// Window sum register: clears on window start, adds zero-extended products, wraps on overflow.
module mac_accumulator
  import cnn_accel_pkg::*;
(
  input  logic                         clk,
  input  logic                         layer_reset,
  input  logic                         clear,
  input  logic                         add_en,
  input  logic [PRODUCT_BIT_WIDTH-1:0] product,
  output logic [ACC_BIT_WIDTH-1:0]     sum
);

  always_ff @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (add_en) begin
      sum <= sum + zext_product(product);
    end
  end

endmodule

// File: rtl/mac_window_sequencer.sv
// Sequences one convolution window of taps through the shared multiplier and returns the sum.
//
//   state    | meaning
//   ST_IDLE  | waiting for start with a non-zero tap count
//   ST_RUN   | issuing operand-buffer reads for taps 0..N-1
//   ST_DRAIN | letting the last products reach the accumulator
//   ST_HOLD  | window sum presented, waiting for acc_ready
module mac_window_sequencer
  import cnn_accel_pkg::*;
(
  input  logic                   clk,
  input  logic                   layer_reset,
  mac_window_sequencer_if.slave  bus
);

  seq_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0]  last_q;
  logic [ADDR_WIDTH-1:0]  addr_q;
  logic [1:0]             drain_q;
  logic                   multi_en_q;
  logic                   add_en_q;
  logic                   accept;
  logic                   last_tap;
  logic [ACC_BIT_WIDTH-1:0] sum;

  // HOLD with acc_ready lets the next window start on the handshake edge.
  assign accept = bus.start && (bus.tap_count != '0) &&
                  ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && bus.acc_ready));
  assign last_tap = (addr_q == last_q);

  always_ff @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_RUN;
      ST_RUN:   if (last_tap) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == '0) state_d = ST_HOLD;
      ST_HOLD: begin
        if (accept) state_d = ST_RUN;
        else if (bus.acc_ready) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      last_q     <= '0;
      addr_q     <= '0;
      drain_q    <= '0;
      multi_en_q <= 1'b0;
      add_en_q   <= 1'b0;
    end else begin
      multi_en_q <= (state_q == ST_RUN);
      add_en_q   <= multi_en_q;

      if (accept) begin
        last_q <= bus.tap_count - 1'b1;
        addr_q <= '0;
      end else if ((state_q == ST_RUN) && !last_tap) begin
        addr_q <= addr_q + 1'b1;
      end

      // Drain timer: loaded on the last read, terminal count at zero moves to HOLD.
      if ((state_q == ST_RUN) && last_tap) begin
        drain_q <= 2'(DRAIN_CYCLES - 1);
      end else if ((state_q == ST_DRAIN) && (drain_q != '0)) begin
        drain_q <= drain_q - 1'b1;
      end
    end
  end

  mac_accumulator u_acc (
    .clk         (clk),
    .layer_reset (layer_reset),
    .clear       (accept),
    .add_en      (add_en_q),
    .product     (bus.product),
    .sum         (sum)
  );

  assign bus.busy          = (state_q != ST_IDLE);
  assign bus.rd_en         = (state_q == ST_RUN);
  assign bus.rd_addr       = addr_q;
  assign bus.multi_en      = multi_en_q;
  assign bus.multiplicator = bus.rd_neuron;
  assign bus.multiplicand  = bus.rd_weight;
  assign bus.acc_valid     = (state_q == ST_HOLD);
  assign bus.acc_data      = sum;

endmodule

// File: tb/tb_mac_window_sequencer.sv
// Directed bench for mac_window_sequencer with a behavioural operand buffer and multiplier.
module tb_mac_window_sequencer;

  logic clk;
  logic layer_reset;
  int   n_asserts;
  int   n_fail;

  logic [7:0] neuron_mem [16];
  logic [7:0] weight_mem [16];

  mac_window_sequencer_if bus ();

  mac_window_sequencer dut (
    .clk         (clk),
    .layer_reset (layer_reset),
    .bus         (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand buffer: one-cycle read latency.
  always @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      bus.rd_neuron <= '0;
      bus.rd_weight <= '0;
    end else if (bus.rd_en) begin
      bus.rd_neuron <= neuron_mem[bus.rd_addr];
      bus.rd_weight <= weight_mem[bus.rd_addr];
    end
  end

  // Multiplier: registered product, zero when not enabled.
  always @(posedge clk or posedge layer_reset) begin
    if (layer_reset) begin
      bus.product <= '0;
    end else if (bus.multi_en) begin
      bus.product <= 20'(bus.multiplicator) * 20'(bus.multiplicand);
    end else begin
      bus.product <= '0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic start_window(input logic [3:0] n);
    bus.start     = 1'b1;
    bus.tap_count = n;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int cyc, output int me_cyc);
    cyc    = 0;
    me_cyc = 0;
    while (!bus.acc_valid && cyc < limit) begin
      if (bus.multi_en) me_cyc++;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  int cyc;
  int me_cyc;

  initial begin
    n_asserts     = 0;
    n_fail        = 0;
    layer_reset   = 1'b1;
    bus.start     = 1'b0;
    bus.tap_count = '0;
    bus.acc_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      neuron_mem[i] = '0;
      weight_mem[i] = '0;
    end

    // Reset state
    #12;
    chk("rst_busy",      32'(bus.busy), 0);
    chk("rst_rd_en",     32'(bus.rd_en), 0);
    chk("rst_multi_en",  32'(bus.multi_en), 0);
    chk("rst_acc_valid", 32'(bus.acc_valid), 0);
    chk("rst_acc_data",  32'(bus.acc_data), 0);
    @(posedge clk); #1;
    layer_reset = 1'b0;
    @(posedge clk); #1;

    // 1: N=3, {1,2,3}x{4,5,6} = 32, latency 5
    neuron_mem[0] = 8'd1; neuron_mem[1] = 8'd2; neuron_mem[2] = 8'd3;
    weight_mem[0] = 8'd4; weight_mem[1] = 8'd5; weight_mem[2] = 8'd6;
    start_window(4'd3);
    chk("t1_busy",    32'(bus.busy), 1);
    chk("t1_rd_en",   32'(bus.rd_en), 1);
    chk("t1_rd_addr", 32'(bus.rd_addr), 0);
    wait_valid(40, cyc, me_cyc);
    chk("t1_valid",    32'(bus.acc_valid), 1);
    chk("t1_latency",  32'(cyc), 5);
    chk("t1_multi_en", 32'(me_cyc), 3);
    chk("t1_data",     32'(bus.acc_data), 32);
    @(posedge clk); #1;
    chk("t1_pulse", 32'(bus.acc_valid), 0);
    chk("t1_idle",  32'(bus.busy), 0);

    // 2: N=15, all 255 -> 975375
    for (int i = 0; i < 15; i++) begin
      neuron_mem[i] = 8'd255;
      weight_mem[i] = 8'd255;
    end
    start_window(4'd15);
    wait_valid(60, cyc, me_cyc);
    chk("t2_valid",    32'(bus.acc_valid), 1);
    chk("t2_latency",  32'(cyc), 17);
    chk("t2_multi_en", 32'(me_cyc), 15);
    chk("t2_data",     32'(bus.acc_data), 975375);
    @(posedge clk); #1;

    // 3: N=2, {10,20}x{3,4} = 110, back-pressure for 10 cycles
    neuron_mem[0] = 8'd10; neuron_mem[1] = 8'd20;
    weight_mem[0] = 8'd3;  weight_mem[1] = 8'd4;
    bus.acc_ready = 1'b0;
    start_window(4'd2);
    wait_valid(40, cyc, me_cyc);
    chk("t3_latency", 32'(cyc), 4);
    for (int i = 0; i < 10; i++) begin
      bus.start     = i[0];
      bus.tap_count = 4'd1;
      chk("t3_hold_valid", 32'(bus.acc_valid), 1);
      chk("t3_hold_data",  32'(bus.acc_data), 110);
      chk("t3_hold_busy",  32'(bus.busy), 1);
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("t3_still_valid", 32'(bus.acc_valid), 1);
    bus.acc_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_release_valid", 32'(bus.acc_valid), 0);
    chk("t3_release_busy",  32'(bus.busy), 0);

    // 4: back-to-back window at the handshake edge, 7*9 = 63
    neuron_mem[0] = 8'd1; neuron_mem[1] = 8'd2; neuron_mem[2] = 8'd3;
    weight_mem[0] = 8'd4; weight_mem[1] = 8'd5; weight_mem[2] = 8'd6;
    start_window(4'd3);
    wait_valid(40, cyc, me_cyc);
    chk("t4_first_data", 32'(bus.acc_data), 32);
    neuron_mem[0] = 8'd7;
    weight_mem[0] = 8'd9;
    start_window(4'd1);
    chk("t4_b2b_valid", 32'(bus.acc_valid), 0);
    chk("t4_b2b_busy",  32'(bus.busy), 1);
    chk("t4_b2b_rd_en", 32'(bus.rd_en), 1);
    wait_valid(40, cyc, me_cyc);
    chk("t4_latency", 32'(cyc), 3);
    chk("t4_data",    32'(bus.acc_data), 63);
    @(posedge clk); #1;

    // 5: reset mid-RUN at tap 2 of 9, then N=1 with 3*3
    for (int i = 0; i < 9; i++) begin
      neuron_mem[i] = 8'(i + 1);
      weight_mem[i] = 8'd2;
    end
    start_window(4'd9);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t5_addr2",     32'(bus.rd_addr), 2);
    chk("t5_pre_multi", 32'(bus.multi_en), 1);
    #2 layer_reset = 1'b1;
    #1;
    chk("t5_rst_busy",   32'(bus.busy), 0);
    chk("t5_rst_rd_en",  32'(bus.rd_en), 0);
    chk("t5_rst_addr",   32'(bus.rd_addr), 0);
    chk("t5_rst_multi",  32'(bus.multi_en), 0);
    chk("t5_rst_mcator", 32'(bus.multiplicator), 0);
    chk("t5_rst_mcand",  32'(bus.multiplicand), 0);
    chk("t5_rst_valid",  32'(bus.acc_valid), 0);
    chk("t5_rst_data",   32'(bus.acc_data), 0);
    #2 layer_reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 12; i++) begin
      chk("t5_no_spurious_valid", 32'(bus.acc_valid), 0);
      chk("t5_no_spurious_busy",  32'(bus.busy), 0);
      @(posedge clk); #1;
    end
    neuron_mem[0] = 8'd3;
    weight_mem[0] = 8'd3;
    start_window(4'd1);
    wait_valid(40, cyc, me_cyc);
    chk("t5_latency", 32'(cyc), 3);
    chk("t5_data",    32'(bus.acc_data), 9);
    @(posedge clk); #1;

    // 6: tap_count = 0 is ignored
    start_window(4'd0);
    for (int i = 0; i < 4; i++) begin
      chk("t6_busy",  32'(bus.busy), 0);
      chk("t6_rd_en", 32'(bus.rd_en), 0);
      chk("t6_valid", 32'(bus.acc_valid), 0);
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
